// File: rtl/seq_pkg.sv
// Shared definitions for the N-slave sequencing controller.
// State encoding and the upper bound on the number of slave channels.
package seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam int MAX_SLAVES = 16;

endpackage

// File: rtl/seq_next_sel.sv
// Combinational priority finder: finds the next enabled slave above the
// current index, and the lowest enabled slave overall.
module seq_next_sel #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] cur_i,
  output logic [IDX_W-1:0] nxt_o,
  output logic             found_o,
  output logic [IDX_W-1:0] low_o,
  output logic             any_o
);

  // Walk from the top down so that the last hit is the lowest qualifying index.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    low_o   = '0;
    any_o   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_o = IDX_W'(i);
        any_o = 1'b1;
        if (i > int'(cur_i)) begin
          nxt_o   = IDX_W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_controller.sv
// N-slave sequencing controller: triggers enabled slaves in ascending order,
// waiting for each done, with loop mode, per-slave timeout and abort.
module seq_controller
  import seq_pkg::*;
#(
  parameter int  N_SLAVES = 4,
  parameter int  TMO_W    = 16,
  localparam int IDX_W    = $clog2(N_SLAVES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                loop_mode,
  input  logic [N_SLAVES-1:0] slave_en,
  input  logic [TMO_W-1:0]    timeout_val,
  input  logic [N_SLAVES-1:0] done,
  output logic [N_SLAVES-1:0] trigger,
  output logic                busy,
  output logic [IDX_W-1:0]    cur_slave,
  output logic                seq_done,
  output logic                err_timeout,
  output logic [IDX_W-1:0]    err_slave,
  output seq_state_e          dbg_state
);

  seq_state_e          state_q;
  logic [IDX_W-1:0]    cur_q;
  logic [N_SLAVES-1:0] trig_q;
  logic                busy_q;
  logic                seq_done_q;
  logic                err_tmo_q;
  logic [IDX_W-1:0]    err_slave_q;
  logic [N_SLAVES-1:0] en_q;
  logic                loop_q;
  logic [TMO_W-1:0]    tmo_val_q;
  logic [TMO_W-1:0]    cnt_q;

  logic [N_SLAVES-1:0] sel_mask;
  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_found;
  logic [IDX_W-1:0]    low_idx;
  logic                any_en;
  logic                done_cur;
  logic                tmo_hit;

  function automatic logic [N_SLAVES-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_SLAVES'(1) << idx;
  endfunction

  // In IDLE the finder looks at the live mask (for the start decision);
  // in RUN it looks only at the mask captured at start.
  assign sel_mask = (state_q == ST_IDLE) ? slave_en : en_q;
  assign done_cur = done[cur_q];
  assign tmo_hit  = (tmo_val_q != '0) && (cnt_q == tmo_val_q - TMO_W'(1));

  seq_next_sel #(
    .N     (N_SLAVES),
    .IDX_W (IDX_W)
  ) u_next_sel (
    .mask_i  (sel_mask),
    .cur_i   (cur_q),
    .nxt_o   (nxt_idx),
    .found_o (nxt_found),
    .low_o   (low_idx),
    .any_o   (any_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      trig_q      <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_slave_q <= '0;
      en_q        <= '0;
      loop_q      <= 1'b0;
      tmo_val_q   <= '0;
      cnt_q       <= '0;
    end else begin
      seq_done_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        trig_q  <= '0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              en_q      <= slave_en;
              loop_q    <= loop_mode;
              tmo_val_q <= timeout_val;
              cnt_q     <= '0;
              if (any_en) begin
                state_q <= ST_RUN;
                cur_q   <= low_idx;
                trig_q  <= onehot(low_idx);
                busy_q  <= 1'b1;
              end else begin
                seq_done_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (done_cur) begin
              cnt_q <= '0;
              if (nxt_found) begin
                cur_q  <= nxt_idx;
                trig_q <= onehot(nxt_idx);
              end else begin
                seq_done_q <= 1'b1;
                if (loop_q) begin
                  cur_q  <= low_idx;
                  trig_q <= onehot(low_idx);
                end else begin
                  state_q <= ST_IDLE;
                  trig_q  <= '0;
                  busy_q  <= 1'b0;
                end
              end
            end else if (tmo_hit) begin
              err_tmo_q   <= 1'b1;
              err_slave_q <= cur_q;
              state_q     <= ST_IDLE;
              trig_q      <= '0;
              busy_q      <= 1'b0;
              cnt_q       <= '0;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + TMO_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            trig_q  <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trigger     = trig_q;
  assign busy        = busy_q;
  assign cur_slave   = cur_q;
  assign seq_done    = seq_done_q;
  assign err_timeout = err_tmo_q;
  assign err_slave   = err_slave_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller (N_SLAVES=4): sequencing, masking, loop,
// abort, timeout, ignored start and asynchronous reset.
module tb_seq_controller;
  import seq_pkg::*;

  localparam int N     = 4;
  localparam int TMO_W = 16;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             loop_mode;
  logic [N-1:0]     slave_en;
  logic [TMO_W-1:0] timeout_val;
  logic [N-1:0]     done;
  logic [N-1:0]     trigger;
  logic             busy;
  logic [IDX_W-1:0] cur_slave;
  logic             seq_done;
  logic             err_timeout;
  logic [IDX_W-1:0] err_slave;
  seq_state_e       dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  logic [N-1:0] exp_q[$];

  seq_controller #(.N_SLAVES(N), .TMO_W(TMO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .loop_mode   (loop_mode),
    .slave_en    (slave_en),
    .timeout_val (timeout_val),
    .done        (done),
    .trigger     (trigger),
    .busy        (busy),
    .cur_slave   (cur_slave),
    .seq_done    (seq_done),
    .err_timeout (err_timeout),
    .err_slave   (err_slave),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs are sampled 1ns after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [N-1:0] en, input logic lp, input logic [TMO_W-1:0] tmo);
    slave_en    = en;
    loop_mode   = lp;
    timeout_val = tmo;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Check the current trigger against the expected queue, then complete
  // the slave with a done pulse on its third trigger cycle.
  task automatic serve(input int idx, input string tag);
    logic [N-1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(trigger), 32'(e));
    repeat (2) tick();
    done[idx] = 1'b1;
    tick();
    done = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
    slave_en = '0; timeout_val = '0; done = '0;
    #12;
    check("rst_trigger", 32'(trigger), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_seq_done", 32'(seq_done), 32'h0);
    check("rst_err", 32'({err_timeout, err_slave, cur_slave}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // 1: full pass over all four slaves
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    start_seq(4'b1111, 1'b0, '0);
    check("t1_busy", 32'(busy), 32'h1);
    for (int i = 0; i < N; i++) serve(i, $sformatf("t1_trig%0d", i));
    check("t1_seq_done", 32'(seq_done), 32'h1);
    check("t1_trig_off", 32'(trigger), 32'h0);
    check("t1_busy_off", 32'(busy), 32'h0);
    tick();
    check("t1_seq_done_pulse", 32'(seq_done), 32'h0);

    // 2: sparse mask, stray done bits ignored
    start_seq(4'b1010, 1'b0, '0);
    check("t2_first", 32'(trigger), 32'b0010);
    check("t2_cur", 32'(cur_slave), 32'd1);
    done = 4'b0101; tick(); done = '0;
    check("t2_stray", 32'(trigger), 32'b0010);
    done = 4'b0010; tick(); done = '0;
    check("t2_next", 32'(trigger), 32'b1000);
    done = 4'b0100; tick(); done = '0;
    check("t2_stray2", 32'(trigger), 32'b1000);
    done = 4'b1000; tick(); done = '0;
    check("t2_seq_done", 32'(seq_done), 32'h1);

    // 3: loop mode wrap, then abort mid-slave-2
    tick();
    start_seq(4'b0101, 1'b1, '0);
    check("t3_first", 32'(trigger), 32'b0001);
    done = 4'b0001; tick(); done = '0;
    check("t3_second", 32'(trigger), 32'b0100);
    done = 4'b0100; tick(); done = '0;
    check("t3_wrap_done", 32'(seq_done), 32'h1);
    check("t3_wrap_trig", 32'(trigger), 32'b0001);
    check("t3_wrap_busy", 32'(busy), 32'h1);
    done = 4'b0001; tick(); done = '0;
    check("t3_again", 32'(trigger), 32'b0100);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("t3_abort_trig", 32'(trigger), 32'h0);
    check("t3_abort_busy", 32'(busy), 32'h0);
    check("t3_abort_flags", 32'({seq_done, err_timeout}), 32'h0);

    // 4: timeout on slave 1 after exactly 5 trigger cycles
    tick();
    start_seq(4'b0011, 1'b0, 16'd5);
    done = 4'b0001; tick(); done = '0;
    cyc = 0;
    while (trigger[1] && cyc < 20) begin
      cyc++;
      tick();
    end
    check("t4_trig_cycles", 32'(cyc), 32'd5);
    check("t4_err_pulse", 32'(err_timeout), 32'h1);
    check("t4_err_slave", 32'(err_slave), 32'd1);
    check("t4_idle", 32'(busy), 32'h0);
    tick();
    check("t4_err_once", 32'(err_timeout), 32'h0);
    check("t4_err_held", 32'(err_slave), 32'd1);
    // done on the fifth cycle beats the timeout
    start_seq(4'b0011, 1'b0, 16'd5);
    done = 4'b0001; tick(); done = '0;
    repeat (4) tick();
    done = 4'b0010; tick(); done = '0;
    check("t4_done_wins_err", 32'(err_timeout), 32'h0);
    check("t4_done_wins_seq", 32'(seq_done), 32'h1);

    // 5: empty mask, start while running, mask change mid-run
    tick();
    start_seq(4'b0000, 1'b0, '0);
    check("t5_empty_done", 32'(seq_done), 32'h1);
    check("t5_empty_busy", 32'(busy), 32'h0);
    tick();
    check("t5_empty_busy2", 32'(busy), 32'h0);
    start_seq(4'b0011, 1'b0, '0);
    slave_en = 4'b1100; start = 1'b1; tick(); start = 1'b0;
    check("t5_no_restart", 32'(trigger), 32'b0001);
    done = 4'b0001; tick(); done = '0;
    check("t5_latched_mask", 32'(trigger), 32'b0010);
    done = 4'b0010; tick(); done = '0;
    check("t5_end", 32'({seq_done, busy}), 32'b10);

    // 6: asynchronous reset mid-run with trigger[2] high
    tick();
    start_seq(4'b0111, 1'b0, '0);
    done = 4'b0001; tick();
    done = 4'b0010; tick(); done = '0;
    check("t6_pre", 32'(trigger), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_trig", 32'(trigger), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_state", 32'(dbg_state), 32'(ST_IDLE));
    #2 rst_n = 1'b1;
    tick();
    start_seq(4'b0111, 1'b0, '0);
    check("t6_restart", 32'(trigger), 32'b0001);
    check("t6_restart_cur", 32'(cur_slave), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t6_final_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Parametrised N-slave sequencing controller; successor to the fixed two-slave start/done sequencer.
- On start, it triggers each enabled slave in ascending index order and waits for that slave's done before moving to the next.
- Adds an enable mask, loop mode, per-slave timeout, abort, and status outputs.
- Sits between the top-level control/CSR logic and the processing engines it schedules.

Parameters:
- N_SLAVES, 4, number of slave channels (2..16).
- TMO_W, 16, width of the per-slave timeout counter.
- IDX_W, $clog2(N_SLAVES), slave index width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority.
- loop_mode  in  1  1 = restart the sequence after the last slave; latched at start.
- slave_en  in  N_SLAVES  enable mask; latched at start.
- timeout_val  in  TMO_W  max cycles per slave; 0 = timeout disabled; latched at start.
- done  in  N_SLAVES  per-slave completion, level or pulse.
- trigger  out  N_SLAVES  one-hot (or zero) registered trigger to slaves.
- busy  out  1  high whenever not IDLE.
- cur_slave  out  IDX_W  index of the slave currently triggered.
- seq_done  out  1  1-cycle pulse at completion of each full pass.
- err_timeout  out  1  1-cycle pulse on timeout.
- err_slave  out  IDX_W  index of the slave that timed out; held until the next error or reset.

Behaviour:
- Reset: state=IDLE; all outputs 0; latched mask/mode/timeout cleared; counter 0.
- States: IDLE, RUN. All outputs are registered.
- IDLE, start=1 at cycle T:
  - Latch slave_en, loop_mode, timeout_val.
  - Mask nonzero: state=RUN; cur_slave = lowest enabled index; trigger[cur] high at T+1; busy high at T+1.
  - Mask zero: seq_done pulses at T+1; remain IDLE; busy stays 0.
- RUN:
  - trigger[cur_slave] is held high; the timeout counter increments each cycle from 0, starting on entry to each slave.
  - done[cur_slave]=1 at cycle T and a higher enabled index exists: at T+1 cur_slave = next enabled index, trigger moves to it with no gap cycle, and the counter clears.
  - done[cur_slave]=1 at T and cur_slave is the last enabled index: seq_done pulses at T+1.
    - loop=0: trigger=0, busy=0, state=IDLE at T+1.
    - loop=1: trigger moves to the lowest enabled index at T+1; state stays RUN; the counter clears.
  - done bits of non-current slaves are ignored.
  - Timeout: timeout_val≠0 and counter == timeout_val-1 with no done at T. At T+1: err_timeout pulses, err_slave=cur_slave, trigger=0, state=IDLE. The slave therefore sees exactly timeout_val trigger cycles.
  - done and timeout in the same cycle: done wins.
- abort=1 in any state at T: at T+1 trigger=0, busy=0, state=IDLE; no seq_done or err pulse. abort has priority over start in the same cycle.
- start while RUN is ignored. Changes to slave_en, loop_mode, or timeout_val during RUN have no effect until the next start.
- The counter saturates at its maximum value and never wraps.
- cur_slave holds its last value in IDLE.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding constants ST_IDLE / ST_RUN;
  - MAX_SLAVES = 16.
- One sub-module, seq_next_sel: a combinational priority finder.
  - Inputs: mask and current index.
  - Outputs: next enabled index above current, a "found" flag, the lowest enabled index, and an "any" flag.
- The counter and FSM stay in seq_controller.

Test Plan:
1. N=4, en=4'b1111, loop=0, tmo=0; start at T; each done asserted 3 cycles after its trigger -> trigger sequence 0001→0010→0100→1000, seq_done at last done+1, busy low afterwards.
2. en=4'b1010, start -> first trigger 4'b0010 at T+1; done[1] -> 4'b1000 next cycle; stray done[0]/done[2] pulses are ignored.
3. loop=1, en=4'b0101 -> after done[2], seq_done pulses and trigger=4'b0001 in the same cycle. Abort mid-slave-2 -> trigger=0 next cycle, no seq_done.
4. tmo=5, slave 1 never completes -> trigger[1] high for exactly 5 cycles, err_timeout pulse, err_slave=1, IDLE. A second run with done[1] in the 5th cycle -> no error (done wins).
5. en=0, start -> seq_done pulse at T+1, busy never asserted. Start during RUN -> no restart. slave_en changed mid-run -> the sequence follows the latched mask.
6. Assert rst_n low mid-RUN with trigger[2] high -> trigger, busy, and flags go 0 immediately (asynchronously); the first start after release begins at the lowest enabled slave.
